// File: rtl/ramb16_arb_pkg.sv
// Shared definitions for the RAMB16 x18 port-B controller/arbiter.
// Holds array geometry, the FSM state type and the per-requester
// request-field bundle used by the port-B mux.
package ramb16_arb_pkg;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 18;

  // One requester's access fields: {we, addr, wdata}
  localparam int unsigned REQ_W = 1 + AW + DW;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/ramb16_s18_port_arb_if.sv
// Requester-side bus of the port-B arbiter.
//   master : the two requesters (drive REQx/WEx/ADDRx/WDATAx)
//   slave  : the arbiter (drives ACKx, RVALIDx, shared RDATA, BUSY)
interface ramb16_s18_port_arb_if;
  import ramb16_arb_pkg::*;

  logic          REQ0;
  logic          REQ1;
  logic          WE0;
  logic          WE1;
  logic [AW-1:0] ADDR0;
  logic [AW-1:0] ADDR1;
  logic [DW-1:0] WDATA0;
  logic [DW-1:0] WDATA1;
  logic          ACK0;
  logic          ACK1;
  logic          RVALID0;
  logic          RVALID1;
  logic [DW-1:0] RDATA;
  logic          BUSY;

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
    input  ACK0, ACK1, RVALID0, RVALID1, RDATA, BUSY
  );

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
    output ACK0, ACK1, RVALID0, RVALID1, RDATA, BUSY
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   req  : request vector, bit x = requester x
//   en   : arbitration enable; no grant when low
//   last : index of the requester granted most recently
//   gnt  : one-hot grant
// A lone request is always granted; on a tie the requester that is not
// `last` wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/ramb16_s18_port_arb.sv
// Controller/arbiter for port B (x18) of a 1024x18 dual-port block RAM.
// After reset (if INIT_ON_RST) or a CLR pulse it sweeps every word with
// INIT_VAL, then shares port B between two requesters round-robin.
// Ports:
//   CLK, RST_N      clock (also RAM CLKB), async active-low reset
//   CLR             one-cycle pulse, (re)starts the fill sweep
//   bus             requester handshake (REQx/WEx/ADDRx/WDATAx in,
//                   ACKx/RVALIDx/RDATA/BUSY out)
//   ENB, WEB, SSRB, ADDRB, DIB, DIPB   RAM port B controls / write data
//   DOB, DOPB       RAM port B read data, returned on RDATA
module ramb16_s18_port_arb
  import ramb16_arb_pkg::*;
#(
  parameter logic [DW-1:0] INIT_VAL    = 18'h00000,
  parameter bit            INIT_ON_RST = 1'b1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CLR,
  ramb16_s18_port_arb_if.slave        bus,
  output logic                        ENB,
  output logic                        WEB,
  output logic                        SSRB,
  output logic [AW-1:0]               ADDRB,
  output logic [15:0]                 DIB,
  output logic [1:0]                  DIPB,
  input  logic [15:0]                 DOB,
  input  logic [1:0]                  DOPB
);

  localparam state_e RST_STATE = INIT_ON_RST ? ST_INIT : ST_RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic          arb_en;
  logic [1:0]    gnt;
  req_fields_t   f0, f1;
  logic          enb_c, web_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;

  assign f0 = '{we: bus.WE0, addr: bus.ADDR0, wdata: bus.WDATA0};
  assign f1 = '{we: bus.WE1, addr: bus.ADDR1, wdata: bus.WDATA1};

  // CLR takes priority over requests in RUN
  assign arb_en = (state_q == ST_RUN) && !CLR;

  rr_arb2 u_arb (
    .req  ({bus.REQ1, bus.REQ0}),
    .en   (arb_en),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    enb_c     = 1'b0;
    web_c     = 1'b0;
    addr_c    = f0.addr;
    wdata_c   = f0.wdata;

    case (state_q)
      ST_INIT: begin
        enb_c   = 1'b1;
        web_c   = 1'b1;
        addr_c  = cnt_q;
        wdata_c = INIT_VAL;
        cnt_d   = cnt_q + 1'b1;
        if (CLR) begin
          cnt_d = '0;
        end else if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (CLR) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (gnt[0]) begin
          enb_c     = 1'b1;
          web_c     = f0.we;
          addr_c    = f0.addr;
          wdata_c   = f0.wdata;
          last_d    = 1'b0;
          rvalid0_d = ~f0.we;
        end else if (gnt[1]) begin
          enb_c     = 1'b1;
          web_c     = f1.we;
          addr_c    = f1.addr;
          wdata_c   = f1.wdata;
          last_d    = 1'b1;
          rvalid1_d = ~f1.we;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Strobes are gated by RST_N so nothing reaches the RAM while reset is
  // asserted, even though the INIT state itself drives ENB/WEB high.
  assign ENB   = enb_c & RST_N;
  assign WEB   = web_c & RST_N;
  assign SSRB  = 1'b0;
  assign ADDRB = addr_c;
  assign DIB   = wdata_c[15:0];
  assign DIPB  = wdata_c[17:16];

  assign bus.ACK0    = gnt[0] & RST_N;
  assign bus.ACK1    = gnt[1] & RST_N;
  assign bus.RVALID0 = rvalid0_q;
  assign bus.RVALID1 = rvalid1_q;
  assign bus.RDATA   = {DOPB, DOB};
  assign bus.BUSY    = (state_q == ST_INIT);

endmodule

// File: tb/tb_ramb16_s18_port_arb.sv
module tb_ramb16_s18_port_arb;
  localparam logic [17:0] IV = 18'h2C3A5;
  localparam logic [17:0] D1 = 18'h2A5A5;
  localparam logic [17:0] D2 = 18'h1F00F;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  always #5 clk = ~clk;

  ramb16_s18_port_arb_if ifa ();
  ramb16_s18_port_arb_if ifb ();

  logic        enb_a, web_a, ssrb_a;
  logic [9:0]  addrb_a;
  logic [15:0] dib_a, dob_a;
  logic [1:0]  dipb_a, dopb_a;
  logic        enb_b, web_b, ssrb_b;
  logic [9:0]  addrb_b;
  logic [15:0] dib_b;
  logic [1:0]  dipb_b;
  logic [15:0] dob_b = 16'h0;
  logic [1:0]  dopb_b = 2'b0;

  ramb16_s18_port_arb #(.INIT_VAL(IV), .INIT_ON_RST(1'b1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .bus(ifa),
    .ENB(enb_a), .WEB(web_a), .SSRB(ssrb_a), .ADDRB(addrb_a),
    .DIB(dib_a), .DIPB(dipb_a), .DOB(dob_a), .DOPB(dopb_a)
  );

  ramb16_s18_port_arb #(.INIT_VAL(IV), .INIT_ON_RST(1'b0)) dut_b (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .bus(ifb),
    .ENB(enb_b), .WEB(web_b), .SSRB(ssrb_b), .ADDRB(addrb_b),
    .DIB(dib_b), .DIPB(dipb_b), .DOB(dob_b), .DOPB(dopb_b)
  );

  // Block RAM port B, WRITE_FIRST, synchronous read
  logic [17:0] ram [1024];
  always @(posedge clk) begin
    if (enb_a) begin
      if (web_a) begin
        ram[addrb_a]     <= {dipb_a, dib_a};
        {dopb_a, dob_a}  <= {dipb_a, dib_a};
      end else begin
        {dopb_a, dob_a}  <= ram[addrb_a];
      end
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.REQ0 = 0; ifa.WE0 = 0; ifa.ADDR0 = '0; ifa.WDATA0 = '0;
    ifa.REQ1 = 0; ifa.WE1 = 0; ifa.ADDR1 = '0; ifa.WDATA1 = '0;
  endtask

  typedef struct {
    logic        r0, w0; logic [9:0] a0; logic [17:0] d0;
    logic        r1, w1; logic [9:0] a1; logic [17:0] d1;
    logic        ea0, ea1, ev0, ev1; logic [17:0] erd;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [9:0] a0, logic [17:0] d0,
                              logic r1, logic w1, logic [9:0] a1, logic [17:0] d1,
                              logic ea0, logic ea1, logic ev0, logic ev1, logic [17:0] erd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ea0 = ea0; v.ea1 = ea1; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
    return v;
  endfunction

  // Sweep check: ADDRB walks 0..1023 with WEB=1 and fill data, BUSY high
  task automatic sweep_check(input string nm, input bit hold_req0);
    int unsigned bad = 0;
    int unsigned nbusy = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ifa.BUSY === 1'b1) nbusy++;
      if (enb_a !== 1'b1 || web_a !== 1'b1 || addrb_a !== 10'(i) ||
          {dipb_a, dib_a} !== IV || ifa.ACK0 !== 1'b0 || ifa.ACK1 !== 1'b0)
        bad++;
      if (hold_req0 && i == 0 && ifa.RVALID0 !== 1'b0) bad++;
      step();
    end
    chk({nm, "_sweep_errs"}, 32'(bad), 32'd0);
    chk({nm, "_busy_cycles"}, 32'(nbusy), 32'd1024);
    chk({nm, "_busy_after"}, 32'(ifa.BUSY), 32'd0);
  endtask

  vec_t tbl[17];
  logic [17:0] mdl_mem [1024];
  int mdl_last;

  initial begin
    int unsigned bad;
    bit pend[2];
    bit rwe[2];
    logic [9:0] raddr[2];
    logic [17:0] rdat[2];
    int g, pv, pv_n;
    logic [17:0] pd, pd_n;

    tbl[0]  = mk(1,0,10'h3FF,'0, 0,0,'0,'0,          1,0, 0,0, '0);
    tbl[1]  = mk(0,0,'0,'0,      0,0,'0,'0,          0,0, 1,0, IV);
    tbl[2]  = mk(1,1,10'h012,D1, 0,0,'0,'0,          1,0, 0,0, '0);
    tbl[3]  = mk(1,0,10'h012,'0, 0,0,'0,'0,          1,0, 0,0, '0);
    tbl[4]  = mk(0,0,'0,'0,      0,0,'0,'0,          0,0, 1,0, D1);
    tbl[5]  = mk(0,0,'0,'0,      1,1,10'h020,D2,     0,1, 0,0, '0);
    tbl[6]  = mk(1,0,10'h012,'0, 1,0,10'h020,'0,     1,0, 0,0, '0);
    tbl[7]  = mk(1,0,10'h012,'0, 1,0,10'h020,'0,     0,1, 1,0, D1);
    tbl[8]  = mk(1,0,10'h012,'0, 1,0,10'h020,'0,     1,0, 0,1, D2);
    tbl[9]  = mk(1,0,10'h012,'0, 1,0,10'h020,'0,     0,1, 1,0, D1);
    tbl[10] = mk(1,0,10'h012,'0, 1,0,10'h020,'0,     1,0, 0,1, D2);
    tbl[11] = mk(1,0,10'h012,'0, 1,0,10'h020,'0,     0,1, 1,0, D1);
    tbl[12] = mk(0,0,'0,'0,      1,0,10'h020,'0,     0,1, 0,1, D2);
    tbl[13] = mk(0,0,'0,'0,      1,0,10'h3FF,'0,     0,1, 0,1, D2);
    tbl[14] = mk(0,0,'0,'0,      1,0,10'h012,'0,     0,1, 0,1, IV);
    tbl[15] = mk(0,0,'0,'0,      0,0,'0,'0,          0,0, 0,1, D1);
    tbl[16] = mk(0,0,'0,'0,      0,0,'0,'0,          0,0, 0,0, '0);

    // ---- reset, interrupted sweep, full sweep ----
    rst_n = 1'b0; clr = 1'b0;
    idle_a();
    ifa.REQ0 = 1'b1;
    ifb.REQ0 = 0; ifb.WE0 = 0; ifb.ADDR0 = '0; ifb.WDATA0 = '0;
    ifb.REQ1 = 1; ifb.WE1 = 0; ifb.ADDR1 = 10'h005; ifb.WDATA1 = '0;
    step(); step();
    chk("rst_enb", 32'(enb_a), 32'd0);
    chk("rst_web", 32'(web_a), 32'd0);
    chk("rst_busy", 32'(ifa.BUSY), 32'd1);
    chk("rst_rvalid0", 32'(ifa.RVALID0), 32'd0);
    chk("rst_ssrb", 32'(ssrb_a), 32'd0);
    chk("b_rst_enb", 32'(enb_b), 32'd0);
    chk("b_rst_busy", 32'(ifb.BUSY), 32'd0);
    ifa.REQ0 = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("b_busy", 32'(ifb.BUSY), 32'd0);
    chk("b_ack1_immediate", 32'(ifb.ACK1), 32'd1);
    chk("b_enb", 32'(enb_b), 32'd1);
    chk("b_addrb", 32'(addrb_b), 32'h005);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (enb_a !== 1'b1 || addrb_a !== 10'(i) || ifa.BUSY !== 1'b1) bad++;
      step();
    end
    ifb.REQ1 = 1'b0;
    chk("partial_sweep_errs", 32'(bad), 32'd0);
    chk("sweep_at_500", 32'(addrb_a), 32'd500);
    rst_n = 1'b0;
    #1;
    chk("midsweep_rst_enb", 32'(enb_a), 32'd0);
    chk("midsweep_rst_busy", 32'(ifa.BUSY), 32'd1);
    chk("midsweep_rst_rvalid", 32'({ifa.RVALID0, ifa.RVALID1}), 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    sweep_check("post_rst", 1'b0);

    // ---- table-driven vectors in RUN ----
    for (int i = 0; i < 17; i++) begin
      ifa.REQ0 = tbl[i].r0; ifa.WE0 = tbl[i].w0; ifa.ADDR0 = tbl[i].a0; ifa.WDATA0 = tbl[i].d0;
      ifa.REQ1 = tbl[i].r1; ifa.WE1 = tbl[i].w1; ifa.ADDR1 = tbl[i].a1; ifa.WDATA1 = tbl[i].d1;
      #1;
      chk($sformatf("tbl%0d_ack0", i), 32'(ifa.ACK0), 32'(tbl[i].ea0));
      chk($sformatf("tbl%0d_ack1", i), 32'(ifa.ACK1), 32'(tbl[i].ea1));
      chk($sformatf("tbl%0d_enb", i), 32'(enb_a), 32'(tbl[i].ea0 | tbl[i].ea1));
      chk($sformatf("tbl%0d_rv0", i), 32'(ifa.RVALID0), 32'(tbl[i].ev0));
      chk($sformatf("tbl%0d_rv1", i), 32'(ifa.RVALID1), 32'(tbl[i].ev1));
      if (tbl[i].ev0 || tbl[i].ev1)
        chk($sformatf("tbl%0d_rdata", i), 32'(ifa.RDATA), 32'(tbl[i].erd));
      if (tbl[i].ea0) begin
        chk($sformatf("tbl%0d_addrb", i), 32'(addrb_a), 32'(tbl[i].a0));
        chk($sformatf("tbl%0d_web", i), 32'(web_a), 32'(tbl[i].w0));
      end
      if (tbl[i].ea1) begin
        chk($sformatf("tbl%0d_addrb", i), 32'(addrb_a), 32'(tbl[i].a1));
        chk($sformatf("tbl%0d_web", i), 32'(web_a), 32'(tbl[i].w1));
      end
      step();
    end

    // ---- CLR in RUN with a pending read and REQ0 held ----
    idle_a();
    ifa.REQ0 = 1'b1; ifa.ADDR0 = 10'h3FF;
    #1;
    chk("clr_pre_ack0", 32'(ifa.ACK0), 32'd1);
    step();
    ifa.ADDR0 = 10'h012;
    clr = 1'b1;
    #1;
    chk("clr_ack0", 32'(ifa.ACK0), 32'd0);
    chk("clr_enb", 32'(enb_a), 32'd0);
    chk("clr_busy", 32'(ifa.BUSY), 32'd0);
    chk("clr_rv0_kept", 32'(ifa.RVALID0), 32'd1);
    chk("clr_rdata", 32'(ifa.RDATA), 32'(IV));
    step();
    clr = 1'b0;
    #1;
    chk("clr_busy_next", 32'(ifa.BUSY), 32'd1);
    chk("clr_addr0", 32'(addrb_a), 32'd0);
    sweep_check("clr", 1'b1);
    chk("clr_first_run_ack0", 32'(ifa.ACK0), 32'd1);
    chk("clr_first_run_addr", 32'(addrb_a), 32'h012);
    step();
    ifa.REQ0 = 1'b0;
    #1;
    chk("clr_read_rv0", 32'(ifa.RVALID0), 32'd1);
    chk("clr_read_rdata", 32'(ifa.RDATA), 32'(IV));
    step();
    mdl_last = 0;

    // ---- randomized traffic vs. reference model ----
    for (int i = 0; i < 1024; i++) mdl_mem[i] = IV;
    pend[0] = 0; pend[1] = 0;
    pv = -1; pd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (!pend[x] && $urandom_range(0, 3) != 0) begin
          pend[x]  = 1'b1;
          rwe[x]   = 1'($urandom_range(0, 1));
          raddr[x] = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 31));
          rdat[x]  = 18'($urandom);
        end
      end
      ifa.REQ0 = pend[0]; ifa.WE0 = rwe[0]; ifa.ADDR0 = raddr[0]; ifa.WDATA0 = rdat[0];
      ifa.REQ1 = pend[1]; ifa.WE1 = rwe[1]; ifa.ADDR1 = raddr[1]; ifa.WDATA1 = rdat[1];
      #1;
      if (pend[0] && pend[1]) g = (mdl_last == 0) ? 1 : 0;
      else if (pend[0])       g = 0;
      else if (pend[1])       g = 1;
      else                    g = -1;
      chk("rnd_ack0", 32'(ifa.ACK0), 32'(g == 0));
      chk("rnd_ack1", 32'(ifa.ACK1), 32'(g == 1));
      chk("rnd_rv0", 32'(ifa.RVALID0), 32'(pv == 0));
      chk("rnd_rv1", 32'(ifa.RVALID1), 32'(pv == 1));
      if (pv >= 0) chk("rnd_rdata", 32'(ifa.RDATA), 32'(pd));
      pv_n = -1; pd_n = '0;
      if (g >= 0) begin
        chk("rnd_addrb", 32'(addrb_a), 32'(raddr[g]));
        chk("rnd_web", 32'(web_a), 32'(rwe[g]));
        if (rwe[g]) begin
          chk("rnd_wdata", 32'({dipb_a, dib_a}), 32'(rdat[g]));
          mdl_mem[raddr[g]] = rdat[g];
        end else begin
          pv_n = g;
          pd_n = mdl_mem[raddr[g]];
        end
        pend[g] = 1'b0;
        mdl_last = g;
      end else begin
        chk("rnd_enb_idle", 32'(enb_a), 32'd0);
      end
      pv = pv_n; pd = pd_n;
      step();
    end

    // ---- reset with a read in flight ----
    idle_a();
    step();
    ifa.REQ0 = 1'b1; ifa.ADDR0 = 10'h005;
    #1;
    chk("mr_ack0", 32'(ifa.ACK0), 32'd1);
    step();
    ifa.REQ0 = 1'b0;
    #1;
    chk("mr_rv0", 32'(ifa.RVALID0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_rv0", 32'(ifa.RVALID0), 32'd0);
    chk("mr_rst_enb", 32'(enb_a), 32'd0);
    chk("mr_rst_busy", 32'(ifa.BUSY), 32'd1);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("mr_sweep_addr", 32'(addrb_a), 32'd0);
    chk("mr_sweep_enb", 32'(enb_a), 32'd1);
    chk("mr_rv0_after", 32'(ifa.RVALID0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
